// File: rtl/cpu6_timer_pkg.sv
// Shared constants and types for the cpu6 machine timer: register offsets,
// CTRL field positions and the packed CTRL payload.
package cpu6_timer_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MTIME_W = 64;
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned OFF_W   = 3;

    localparam logic [OFF_W-1:0] CPU6_TIMER_OFF_MTIME_LO    = 3'd0;
    localparam logic [OFF_W-1:0] CPU6_TIMER_OFF_MTIME_HI    = 3'd1;
    localparam logic [OFF_W-1:0] CPU6_TIMER_OFF_MTIMECMP_LO = 3'd2;
    localparam logic [OFF_W-1:0] CPU6_TIMER_OFF_MTIMECMP_HI = 3'd3;
    localparam logic [OFF_W-1:0] CPU6_TIMER_OFF_CTRL        = 3'd4;

    localparam int unsigned CPU6_TIMER_CTRL_EN_BIT = 0;
    localparam int unsigned CPU6_TIMER_DIV_HIGH    = 15;
    localparam int unsigned CPU6_TIMER_DIV_LOW     = 8;

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic             en;
    } timer_ctrl_t;

    // CTRL as seen on the read bus; undefined bits read 0.
    function automatic logic [XLEN-1:0] ctrl_to_word(input timer_ctrl_t c);
        logic [XLEN-1:0] w;
        w = '0;
        w[CPU6_TIMER_CTRL_EN_BIT] = c.en;
        w[CPU6_TIMER_DIV_HIGH:CPU6_TIMER_DIV_LOW] = c.div;
        return w;
    endfunction

endpackage

// File: rtl/cpu6_timer_prescaler.sv
// Programmable prescaler: tick every DIV+1 enabled cycles; holds while
// disabled and restarts from 0 on clr.
module cpu6_timer_prescaler
    import cpu6_timer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             clr,
    output logic             tick
);

    logic [DIV_W-1:0] pcnt;

    // Tick is decoded from the current count so it lines up with the edge that wraps pcnt.
    assign tick = en && (pcnt == div);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (clr || tick) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= pcnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/cpu6_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, CTRL, bus decode and
// registered level interrupt to the cpu6 core.
module cpu6_timer
    import cpu6_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] dataaddr,
    input  logic [XLEN-1:0] writedata,
    input  logic            memwriteM,
    output logic            timer_sel,
    output logic [XLEN-1:0] timer_readdata,
    output logic            tmr_irq_r
);

    logic [OFF_W-1:0]   off;
    logic               wr;
    logic               wr_mtime_lo;
    logic               wr_mtime_hi;
    logic               wr_cmp_lo;
    logic               wr_cmp_hi;
    logic               wr_ctrl;
    logic               tick;
    logic               cmp_hit;
    logic [MTIME_W-1:0] mtime;
    logic [MTIME_W-1:0] mtime_nxt;
    logic [MTIME_W-1:0] mtimecmp;
    timer_ctrl_t        ctrl;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^dataaddr[1:0];

    // Address decode: 32-byte window, word-granular offsets.
    assign timer_sel   = (dataaddr[31:5] == BASE_ADDR[31:5]);
    assign off         = dataaddr[4:2];
    assign wr          = memwriteM && timer_sel;
    assign wr_mtime_lo = wr && (off == CPU6_TIMER_OFF_MTIME_LO);
    assign wr_mtime_hi = wr && (off == CPU6_TIMER_OFF_MTIME_HI);
    assign wr_cmp_lo   = wr && (off == CPU6_TIMER_OFF_MTIMECMP_LO);
    assign wr_cmp_hi   = wr && (off == CPU6_TIMER_OFF_MTIMECMP_HI);
    assign wr_ctrl     = wr && (off == CPU6_TIMER_OFF_CTRL);

    cpu6_timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl.en),
        .div   (ctrl.div),
        .clr   (wr_ctrl),
        .tick  (tick)
    );

    // A store to either half overrides the tick; the untouched half keeps its old value.
    always_comb begin
        mtime_nxt = mtime;
        if (tick) begin
            mtime_nxt = mtime + MTIME_W'(1);
        end
        if (wr_mtime_lo) begin
            mtime_nxt = {mtime[63:32], writedata};
        end else if (wr_mtime_hi) begin
            mtime_nxt = {writedata, mtime[31:0]};
        end
    end

    assign cmp_hit = (mtime >= mtimecmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime    <= '0;
            mtimecmp <= '1;
            ctrl     <= '0;
        end else begin
            mtime <= mtime_nxt;
            if (wr_cmp_lo) begin
                mtimecmp[31:0] <= writedata;
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= writedata;
            end
            if (wr_ctrl) begin
                ctrl.en  <= writedata[CPU6_TIMER_CTRL_EN_BIT];
                ctrl.div <= writedata[CPU6_TIMER_DIV_HIGH:CPU6_TIMER_DIV_LOW];
            end
        end
    end

    // Interrupt is a registered level of the current compare result.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_irq_r <= 1'b0;
        end else begin
            tmr_irq_r <= ctrl.en && cmp_hit;
        end
    end

    always_comb begin
        timer_readdata = '0;
        if (timer_sel) begin
            case (off)
                CPU6_TIMER_OFF_MTIME_LO:    timer_readdata = mtime[31:0];
                CPU6_TIMER_OFF_MTIME_HI:    timer_readdata = mtime[63:32];
                CPU6_TIMER_OFF_MTIMECMP_LO: timer_readdata = mtimecmp[31:0];
                CPU6_TIMER_OFF_MTIMECMP_HI: timer_readdata = mtimecmp[63:32];
                CPU6_TIMER_OFF_CTRL:        timer_readdata = ctrl_to_word(ctrl);
                default:                    timer_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6_timer.sv
// Self-checking bench for cpu6_timer: directed scenarios plus random bus
// traffic compared against a cycle-level reference model of the timer.
module tb_cpu6_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk;
    logic        reset;
    logic [31:0] dataaddr;
    logic [31:0] writedata;
    logic        memwriteM;
    logic        timer_sel;
    logic [31:0] timer_readdata;
    logic        tmr_irq_r;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] m_mt;
    logic [63:0] m_cmp;
    logic        m_en;
    logic [7:0]  m_div;
    int unsigned m_phase;
    logic        m_irq;

    cpu6_timer #(.BASE_ADDR(BASE)) dut (
        .clk            (clk),
        .reset          (reset),
        .dataaddr       (dataaddr),
        .writedata      (writedata),
        .memwriteM      (memwriteM),
        .timer_sel      (timer_sel),
        .timer_readdata (timer_readdata),
        .tmr_irq_r      (tmr_irq_r)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_mt    = 64'h0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en    = 1'b0;
        m_div   = 8'h0;
        m_phase = 0;
        m_irq   = 1'b0;
    endtask

    // One clock of the timer: ticks fall on every (DIV+1)th enabled cycle since the last CTRL write.
    task automatic model_step(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        logic        sel;
        logic        tk;
        logic        n_irq;
        int unsigned period;
        logic [63:0] n_mt;
        sel    = (addr[31:5] == BASE[31:5]);
        period = 32'(m_div) + 1;
        tk     = m_en && ((m_phase % period) == period - 1);
        n_irq  = m_en && (m_mt >= m_cmp);
        n_mt   = tk ? m_mt + 64'd1 : m_mt;
        if (m_en) m_phase = m_phase + 1;
        if (we && sel) begin
            case (addr[4:2])
                3'd0: n_mt = {m_mt[63:32], wd};
                3'd1: n_mt = {wd, m_mt[31:0]};
                3'd2: m_cmp[31:0] = wd;
                3'd3: m_cmp[63:32] = wd;
                3'd4: begin
                    m_en    = wd[0];
                    m_div   = wd[15:8];
                    m_phase = 0;
                end
                default: ;
            endcase
        end
        m_mt  = n_mt;
        m_irq = n_irq;
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] addr);
        if (addr[31:5] != BASE[31:5]) return 32'h0;
        case (addr[4:2])
            3'd0:    return m_mt[31:0];
            3'd1:    return m_mt[63:32];
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return {16'h0, m_div, 7'h0, m_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] v);
        memwriteM = 1'b0;
        dataaddr  = BASE + (32'(off) << 2);
        #1;
        v = timer_readdata;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] v;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk($sformatf("%s.off%0d", tag, i * 4), v, exp_read(BASE + 32'(i * 4)));
        end
        chk({tag, ".sel"}, {31'h0, timer_sel}, 32'h1);
        chk({tag, ".irq"}, {31'h0, tmr_irq_r}, {31'h0, m_irq});
    endtask

    // Present one bus cycle, advance the model, and step to just after the edge.
    task automatic cycle(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        memwriteM = we;
        dataaddr  = addr;
        writedata = wd;
        model_step(we, addr, wd);
        @(posedge clk);
        #1;
        memwriteM = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, BASE, 32'h0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        memwriteM = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    logic [31:0] v;
    logic [31:0] v2;

    initial begin
        reset     = 1'b1;
        dataaddr  = BASE;
        writedata = 32'h0;
        memwriteM = 1'b0;
        model_reset();
        do_reset();

        // Reset values
        check_all("reset");
        rd(3'd0, v);  chk("rst_mtime_lo", v, 32'h0);
        rd(3'd3, v);  chk("rst_cmp_hi", v, 32'hFFFF_FFFF);
        rd(3'd4, v);  chk("rst_ctrl", v, 32'h0);
        rd(3'd5, v);  chk("rst_off14", v, 32'h0);
        chk("rst_irq", {31'h0, tmr_irq_r}, 32'h0);

        // EN with DIV=3: first tick four cycles after the store, then every four cycles
        cycle(1'b1, BASE + 32'h10, 32'h0000_0301);
        for (int i = 0; i < 3; i++) begin
            check_all("div3_pre");
            idle();
        end
        rd(3'd0, v); chk("div3_before_tick", v, 32'd0);
        idle();
        rd(3'd0, v); chk("div3_first_tick", v, 32'd1);
        for (int i = 0; i < 40; i++) begin
            check_all("div3_run");
            idle();
        end
        rd(3'd0, v); chk("div3_after40", v, 32'd11);

        // Carry from LO into HI
        cycle(1'b1, BASE + 32'h10, 32'h0);
        cycle(1'b1, BASE + 32'h00, 32'hFFFF_FFFE);
        cycle(1'b1, BASE + 32'h04, 32'h0);
        cycle(1'b1, BASE + 32'h10, 32'h1);
        rd(3'd0, v); chk("carry_lo0", v, 32'hFFFF_FFFE);
        idle();
        check_all("carry");
        idle();
        rd(3'd0, v); chk("carry_lo", v, 32'h0);
        rd(3'd1, v); chk("carry_hi", v, 32'h1);

        // 64-bit wrap
        cycle(1'b1, BASE + 32'h10, 32'h0);
        cycle(1'b1, BASE + 32'h00, 32'hFFFF_FFFF);
        cycle(1'b1, BASE + 32'h04, 32'hFFFF_FFFF);
        cycle(1'b1, BASE + 32'h10, 32'h1);
        rd(3'd1, v); chk("wrap_hi_pre", v, 32'hFFFF_FFFF);
        idle();
        rd(3'd0, v); chk("wrap_lo", v, 32'h0);
        rd(3'd1, v); chk("wrap_hi", v, 32'h0);

        // Interrupt rise at mtime == mtimecmp, then clear by raising mtimecmp
        cycle(1'b1, BASE + 32'h10, 32'h0);
        cycle(1'b1, BASE + 32'h00, 32'd100);
        cycle(1'b1, BASE + 32'h04, 32'h0);
        cycle(1'b1, BASE + 32'h0C, 32'hFFFF_FFFF);
        cycle(1'b1, BASE + 32'h08, 32'd105);
        cycle(1'b1, BASE + 32'h0C, 32'h0);
        cycle(1'b1, BASE + 32'h10, 32'h1);
        for (int i = 0; i < 5; i++) begin
            check_all("irq_ramp");
            idle();
        end
        rd(3'd0, v); chk("irq_mtime105", v, 32'd105);
        chk("irq_low_at_105", {31'h0, tmr_irq_r}, 32'h0);
        idle();
        chk("irq_rise", {31'h0, tmr_irq_r}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            check_all("irq_hold");
            chk("irq_level", {31'h0, tmr_irq_r}, 32'h1);
            idle();
        end
        cycle(1'b1, BASE + 32'h08, 32'd1000);
        chk("irq_still_high", {31'h0, tmr_irq_r}, 32'h1);
        idle();
        chk("irq_cleared", {31'h0, tmr_irq_r}, 32'h0);
        rd(3'd0, v); chk("irq_mtime111", v, 32'd111);

        // Store beats tick for the written half only
        cycle(1'b1, BASE + 32'h04, 32'h7);
        rd(3'd0, v); chk("wr_hi_lo_kept", v, 32'd111);
        rd(3'd1, v); chk("wr_hi_val", v, 32'h7);
        cycle(1'b1, BASE + 32'h00, 32'h55);
        rd(3'd0, v); chk("wr_lo_wins", v, 32'h55);
        rd(3'd1, v); chk("wr_lo_hi_kept", v, 32'h7);
        idle();
        rd(3'd0, v); chk("wr_lo_then_tick", v, 32'h56);

        // Out-of-window stores
        dataaddr  = BASE + 32'h20;
        memwriteM = 1'b1;
        writedata = 32'hDEAD_BEEF;
        #1;
        chk("oow_sel", {31'h0, timer_sel}, 32'h0);
        chk("oow_rdata", timer_readdata, 32'h0);
        cycle(1'b1, BASE + 32'h20, 32'hDEAD_BEEF);
        cycle(1'b1, BASE - 32'h4, 32'hDEAD_BEEF);
        check_all("oow");
        rd(3'd0, v); chk("oow_mtime", v, 32'h58);
        rd(3'd1, v); chk("oow_hi", v, 32'h7);

        // Unmapped offsets ignore writes and read 0
        cycle(1'b1, BASE + 32'h14, 32'hFFFF_FFFF);
        cycle(1'b1, BASE + 32'h1F, 32'hFFFF_FFFF);
        check_all("unmapped");

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic        we;
            logic [2:0]  off;
            logic [31:0] addr;
            logic [31:0] wd;
            check_all("rand");
            we   = ($urandom_range(0, 9) < 4);
            off  = 3'($urandom_range(0, 7));
            addr = BASE + (32'(off) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = BASE + 32'h20 + 32'($urandom_range(0, 31));
            case (off)
                3'd0, 3'd2: wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 60));
                3'd1, 3'd3: wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'h0;
                3'd4: begin
                    wd = $urandom;
                    wd[15:8] = 8'($urandom_range(0, 3));
                    if ($urandom_range(0, 3) != 0) wd[0] = 1'b1;
                end
                default: wd = $urandom;
            endcase
            cycle(we, addr, wd);
        end
        check_all("rand_end");

        // Reset mid-count with the interrupt asserted
        cycle(1'b1, BASE + 32'h0C, 32'h0);
        cycle(1'b1, BASE + 32'h08, 32'h0);
        cycle(1'b1, BASE + 32'h10, 32'h0000_0201);
        idle();
        idle();
        chk("pre_reset_irq", {31'h0, tmr_irq_r}, 32'h1);
        check_all("pre_reset");
        do_reset();
        check_all("mid_reset");
        rd(3'd0, v);  chk("mid_rst_lo", v, 32'h0);
        rd(3'd2, v2); chk("mid_rst_cmp_lo", v2, 32'hFFFF_FFFF);
        rd(3'd4, v);  chk("mid_rst_ctrl", v, 32'h0);
        chk("mid_rst_irq", {31'h0, tmr_irq_r}, 32'h0);
        idle();
        rd(3'd0, v);  chk("post_rst_hold", v, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
